// File: rtl/neuro_xbar_wb_ctrl.sv
// Wishbone command sequencer for N_BANKS crossbar macros: queued READ/SET commands, status and IRQ.
// Optional WAIT-state timeout is enabled with `define NEURO_XBAR_TIMEOUT_EN.
module neuro_xbar_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned N_BANKS    = 4,
  parameter int unsigned ROWS       = 32,
  parameter int unsigned COLS       = 32,
  parameter int unsigned DW         = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic [31:0]               wbs_dat_o,
  output logic                      wbs_ack_o,
  output logic [N_BANKS-1:0]        mac_en,
  output logic                      mac_we,
  output logic [$clog2(ROWS)-1:0]   mac_row,
  output logic [$clog2(COLS)-1:0]   mac_col,
  output logic [DW-1:0]             mac_wdata,
  input  logic [N_BANKS*DW-1:0]     mac_rdata,
  input  logic [N_BANKS-1:0]        mac_done,
  output logic                      irq
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = 1 + 3 + RW + CW + DW;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e              state_q;
  logic                ack_q;
  logic [31:0]         dat_o_q;
  logic                irq_en_q, ovf_q, err_q, rd_valid_q;
  logic [DW-1:0]       rdata_q;
  logic [N_BANKS-1:0]  mac_en_q;
  logic                op_q;
  logic [2:0]          bank_q;
  logic [RW-1:0]       row_q;
  logic [CW-1:0]       col_q;
  logic [DW-1:0]       wdata_q;

  // Wishbone decode
  logic       match, req, wr, rd;
  logic [2:0] idx;

  assign match = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req   = match & ~ack_q;
  assign wr    = req & wbs_we_i & (wbs_sel_i == 4'hF);
  assign rd    = req & ~wbs_we_i;
  assign idx   = wbs_adr_i[4:2];

  // Command FIFO
  logic [EW-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   count_q;
  logic          full, empty, push, pop, push_req, bank_ok, cmd_wr, ovf_set;
  logic [EW-1:0] push_entry;
  logic          pop_op;
  logic [2:0]    pop_bank;
  logic [RW-1:0] pop_row;
  logic [CW-1:0] pop_col;
  logic [DW-1:0] pop_data;

  assign full     = (count_q == (PW+1)'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = (state_q == StIdle) & ~empty;
  assign cmd_wr   = wr & (idx == 3'd2);
  assign bank_ok  = ({29'd0, wbs_dat_i[30:28]} < N_BANKS);
  assign push_req = cmd_wr & bank_ok;
  // A pop in the same cycle frees a slot, so a push while full is still accepted.
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;

  assign push_entry = {wbs_dat_i[31], wbs_dat_i[30:28], wbs_dat_i[22 +: RW],
                       wbs_dat_i[16 +: CW], wbs_dat_i[DW-1:0]};
  assign {pop_op, pop_bank, pop_row, pop_col, pop_data} = fifo_q[rptr_q];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= push_entry;
        wptr_q         <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Per-bank selection of done and read data for the active command
  logic          done_sel;
  logic [DW-1:0] rd_sel;

  always_comb begin
    done_sel = 1'b0;
    rd_sel   = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      if (bank_q == 3'(b)) begin
        done_sel = mac_done[b];
        rd_sel   = mac_rdata[b*DW +: DW];
      end
    end
  end

  logic timeout_hit;

`ifdef NEURO_XBAR_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      tmo_q <= '0;
    end else if (state_q != StWait) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TW'(1);
    end
  end

  assign timeout_hit = (state_q == StWait) & ~done_sel & (tmo_q == TW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
`endif

  // Sequencer FSM with registered macro-side outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= StIdle;
      mac_en_q <= '0;
      op_q     <= 1'b0;
      bank_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      wdata_q  <= '0;
    end else begin
      mac_en_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            state_q <= StIssue;
            op_q    <= pop_op;
            bank_q  <= pop_bank;
            row_q   <= pop_row;
            col_q   <= pop_col;
            wdata_q <= pop_data;
            for (int b = 0; b < N_BANKS; b++) mac_en_q[b] <= (pop_bank == 3'(b));
          end
        end
        StIssue: state_q <= StWait;
        StWait: begin
          if (done_sel)         state_q <= StDone;
          else if (timeout_hit) state_q <= StIdle;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read data is taken alongside mac_done so rd_valid rises the cycle after done.
  logic rd_capture, err_set, clr_wr;

  assign rd_capture = (state_q == StWait) & done_sel & ~op_q;
  assign err_set    = (cmd_wr & ~bank_ok) | timeout_hit;
  assign clr_wr     = wr & (idx == 3'd4);

  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (idx)
      3'd0:    rd_mux[0] = irq_en_q;
      3'd1:    rd_mux = {19'd0, 5'(count_q), 2'd0, err_q, ovf_q, rd_valid_q, empty, full,
                         (state_q != StIdle) | ~empty};
      3'd3:    rd_mux = 32'(rdata_q);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q      <= 1'b0;
      dat_o_q    <= '0;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ack_q <= req;
      if (rd) dat_o_q <= rd_mux;
      if (wr && idx == 3'd0) irq_en_q <= wbs_dat_i[0];
      if (ovf_set)                   ovf_q <= 1'b1;
      else if (clr_wr && wbs_dat_i[0]) ovf_q <= 1'b0;
      if (err_set)                   err_q <= 1'b1;
      else if (clr_wr && wbs_dat_i[1]) err_q <= 1'b0;
      if (rd_capture) begin
        rd_valid_q <= 1'b1;
        rdata_q    <= rd_sel;
      end else if (rd && idx == 3'd3) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[7:5], wbs_adr_i[1:0], wbs_dat_i};

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_o_q;
  assign mac_en    = mac_en_q;
  assign mac_we    = op_q;
  assign mac_row   = row_q;
  assign mac_col   = col_q;
  assign mac_wdata = wdata_q;
  assign irq       = irq_en_q & (rd_valid_q | err_q | ovf_q);

endmodule

// File: tb/tb_neuro_xbar_wb_ctrl.sv
// Directed self-checking bench for neuro_xbar_wb_ctrl (4 banks, 32x32, DW=8, FIFO depth 4).
module tb_neuro_xbar_wb_ctrl;

`ifdef NEURO_XBAR_TIMEOUT_EN
  localparam int unsigned Tmo = 16;
`else
  localparam int unsigned Tmo = 1024;
`endif
  localparam logic [31:0] ACtrl = 32'h3000_0000;
  localparam logic [31:0] AStat = 32'h3000_0004;
  localparam logic [31:0] ACmd  = 32'h3000_0008;
  localparam logic [31:0] ARdat = 32'h3000_000C;
  localparam logic [31:0] AClr  = 32'h3000_0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat_i = '0;
  logic [31:0] dat_o;
  logic        ack;
  logic [3:0]  mac_en;
  logic        mac_we;
  logic [4:0]  mac_row, mac_col;
  logic [7:0]  mac_wdata;
  logic [31:0] mac_rdata = 32'h00A5_0000;
  logic [3:0]  mac_done = 4'h0;
  logic        irq;

  int n_checks = 0;
  int n_fail = 0;
  int en_pulses = 0;
  int cyc_cnt = 0;

  neuro_xbar_wb_ctrl #(
    .BASE_ADDR(32'h3000_0000), .N_BANKS(4), .ROWS(32), .COLS(32), .DW(8),
    .FIFO_DEPTH(4), .TIMEOUT(Tmo)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
    .mac_en(mac_en), .mac_we(mac_we), .mac_row(mac_row), .mac_col(mac_col),
    .mac_wdata(mac_wdata), .mac_rdata(mac_rdata), .mac_done(mac_done), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (mac_en != 4'h0) en_pulses <= en_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cmd_word(input logic op, input logic [2:0] bank,
                                           input logic [5:0] row, input logic [5:0] col,
                                           input logic [15:0] data);
    return {op, bank, row, col, data};
  endfunction

  task automatic wb_xfer(input logic [31:0] a, input logic [31:0] d, input logic w,
                         input logic [3:0] s, output logic [31:0] rdat, output logic acked);
    stb = 1'b1; cyc = 1'b1; we = w; sel = s; adr = a; dat_i = d;
    acked = 1'b0;
    rdat  = 32'hDEAD_BEEF;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(posedge clk); #1;
      acked = ack;
    end
    if (acked) rdat = dat_o;
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic        k;
    wb_xfer(a, d, 1'b1, 4'hF, r, k);
    check(tag, 32'(k), 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic        k;
    wb_xfer(a, 32'd0, 1'b0, 4'hF, r, k);
    check(tag, r, exp);
  endtask

  task automatic wait_en(output logic [3:0] en);
    en = 4'h0;
    for (int i = 0; i < 40 && en == 4'h0; i++) begin
      @(posedge clk); #1;
      en = mac_en;
    end
  endtask

  task automatic pulse_done(input logic [3:0] d);
    mac_done = d;
    tick(1);
    mac_done = 4'h0;
  endtask

  initial begin
    logic [3:0]  en;
    logic [31:0] r;
    logic        k;
    int          base, t1;

    tick(3);
    check("reset_mac_en", 32'(mac_en), 32'd0);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // STATUS read with strobe held: ack for exactly one cycle
    stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF; adr = AStat;
    tick(1);
    check("status_ack", 32'(ack), 32'd1);
    check("status_reset", dat_o, 32'h0000_0004);
    tick(1);
    check("ack_one_cycle", 32'(ack), 32'd0);
    stb = 1'b0; cyc = 1'b0;
    tick(1);

    // SET bank0 row3 col12 data 0x55
    base = en_pulses;
    wr("set_wr", ACmd, cmd_word(1'b1, 3'd0, 6'd3, 6'd12, 16'h0055));
    tick(1);
    check("set_en", 32'(mac_en), 32'h1);
    check("set_we", 32'(mac_we), 32'd1);
    check("set_row", 32'(mac_row), 32'd3);
    check("set_col", 32'(mac_col), 32'd12);
    check("set_wdata", 32'(mac_wdata), 32'h55);
    tick(1);
    check("set_en_low", 32'(mac_en), 32'd0);
    check("set_row_held", 32'(mac_row), 32'd3);
    check("set_en_pulses", 32'(en_pulses - base), 32'd1);
    pulse_done(4'b0001);
    tick(2);
    rd_chk("set_idle", AStat, 32'h0000_0004);

    // READ bank2 row1 col1, done after 5 cycles
    wr("ctrl_wr", ACtrl, 32'h1);
    wr("read_wr", ACmd, cmd_word(1'b0, 3'd2, 6'd1, 6'd1, 16'h0));
    wait_en(en);
    check("read_en", 32'(en), 32'h4);
    check("read_we", 32'(mac_we), 32'd0);
    tick(5);
    pulse_done(4'b0100);
    tick(2);
    check("read_irq", 32'(irq), 32'd1);
    rd_chk("read_status", AStat, 32'h0000_000C);
    rd_chk("read_rdata", ARdat, 32'h0000_00A5);
    check("read_irq_clr", 32'(irq), 32'd0);
    rd_chk("read_status_clr", AStat, 32'h0000_0004);
    rd_chk("ctrl_rd", ACtrl, 32'h1);

    // Overflow: bank1 stalls, then five more commands
    base = en_pulses;
    wr("ovf_first", ACmd, cmd_word(1'b1, 3'd1, 6'd0, 6'd0, 16'h11));
    wait_en(en);
    check("ovf_first_en", 32'(en), 32'h2);
    for (int i = 0; i < 5; i++) wr("ovf_push", ACmd, cmd_word(1'b1, 3'd1, 6'(i), 6'(i), 16'(i)));
    rd_chk("ovf_status", AStat, 32'h0000_0413);
    check("ovf_irq", 32'(irq), 32'd1);
    wr("ovf_clr", AClr, 32'h1);
    rd_chk("ovf_cleared", AStat, 32'h0000_0403);
    for (int i = 0; i < 5; i++) begin
      pulse_done(4'b0010);
      if (i < 4) begin
        wait_en(en);
        check("drain_en", 32'(en), 32'h2);
        tick(1);
      end
    end
    tick(3);
    check("ovf_en_pulses", 32'(en_pulses - base), 32'd5);
    rd_chk("drain_status", AStat, 32'h0000_0004);

    // Invalid bank
    base = en_pulses;
    wr("bad_bank_wr", ACmd, cmd_word(1'b1, 3'd5, 6'd0, 6'd0, 16'h0));
    tick(4);
    check("bad_bank_no_en", 32'(en_pulses - base), 32'd0);
    rd_chk("bad_bank_err", AStat, 32'h0000_0024);
    wr("err_clr", AClr, 32'h2);
    rd_chk("err_cleared", AStat, 32'h0000_0004);

    // Spurious done from another bank during a bank0 WAIT
    wr("spur_wr", ACmd, cmd_word(1'b1, 3'd0, 6'd0, 6'd0, 16'h77));
    wait_en(en);
    check("spur_en", 32'(en), 32'h1);
    tick(1);
    pulse_done(4'b0010);
    tick(2);
    rd_chk("spur_busy", AStat, 32'h0000_0005);
    pulse_done(4'b0001);
    tick(2);
    rd_chk("spur_done", AStat, 32'h0000_0004);

`ifdef NEURO_XBAR_TIMEOUT_EN
    // Bank3 never answers; timeout sets err and the queued command issues
    mac_rdata = 32'h5AA5_0000;
    wr("tmo_rd_wr", ACmd, cmd_word(1'b0, 3'd3, 6'd2, 6'd2, 16'h0));
    wait_en(en);
    check("tmo_first_en", 32'(en), 32'h8);
    t1 = cyc_cnt;
    wr("tmo_next_wr", ACmd, cmd_word(1'b1, 3'd0, 6'd4, 6'd4, 16'h99));
    wait_en(en);
    check("tmo_next_en", 32'(en), 32'h1);
    check("tmo_latency", 32'(cyc_cnt - t1), 32'd18);
    rd_chk("tmo_status", AStat, 32'h0000_0025);
    rd_chk("tmo_rdata_kept", ARdat, 32'h0000_00A5);
    pulse_done(4'b0001);
    tick(2);
    wr("tmo_clr", AClr, 32'h2);
    rd_chk("tmo_cleared", AStat, 32'h0000_0004);
`endif

    // Partial byte select ignored, unmatched address not acked, unmapped reads 0
    wb_xfer(ACtrl, 32'h0, 1'b1, 4'h3, r, k);
    check("sel_ack", 32'(k), 32'd1);
    rd_chk("sel_ignored", ACtrl, 32'h1);
    wb_xfer(32'h4000_0008, cmd_word(1'b1, 3'd0, 6'd0, 6'd0, 16'h1), 1'b1, 4'hF, r, k);
    check("nomatch_noack", 32'(k), 32'd0);
    rd_chk("nomatch_status", AStat, 32'h0000_0004);
    rd_chk("unmapped", 32'h3000_0014, 32'h0);

    // Reset while a command is in ISSUE
    wr("rst_cmd_wr", ACmd, cmd_word(1'b1, 3'd2, 6'd5, 6'd6, 16'h33));
    wait_en(en);
    check("rst_cmd_en", 32'(en), 32'h4);
    rst_n = 1'b0;
    #1;
    check("rst_async_en", 32'(mac_en), 32'd0);
    check("rst_async_row", 32'(mac_row), 32'd0);
    check("rst_async_we", 32'(mac_we), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    rd_chk("rst_status", AStat, 32'h0000_0004);
    rd_chk("rst_ctrl", ACtrl, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
